// File: rtl/vic_pkg.sv
// Shared definitions for the vectored interrupt controller: register map,
// controller state encoding and the vector index width.
package vic_pkg;

  localparam int VEC_W = 5;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_EDGE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SERVICE,
    ST_RETIRE
  } vic_state_e;

  function automatic logic [31:0] status_word(input logic busy,
                                              input logic [VEC_W-1:0] idx);
    return {26'b0, busy, idx};
  endfunction

endpackage

// File: rtl/vic_irq_if.sv
// Signal bundle between a bus/peripheral side and the interrupt controller.
interface vic_irq_if
  import vic_pkg::*;
#(
  parameter int NSRC = 32
);
  logic [NSRC-1:0]  src;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;
  logic             reti;
  logic             irq;
  logic [VEC_W-1:0] isr_addr;
  logic             busy;

  modport master (
    output src, cfg_we, cfg_addr, cfg_wdata, reti,
    input  cfg_rdata, irq, isr_addr, busy
  );

  modport slave (
    input  src, cfg_we, cfg_addr, cfg_wdata, reti,
    output cfg_rdata, irq, isr_addr, busy
  );

endinterface

// File: rtl/vic_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module vic_prio_enc
  import vic_pkg::*;
#(
  parameter int NSRC = 32
) (
  input  logic [NSRC-1:0]  i_req,
  output logic             o_vld,
  output logic [VEC_W-1:0] o_idx
);

  always_comb begin
    o_vld = |i_req;
    o_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = VEC_W'(i);
    end
  end

endmodule

// File: rtl/vic_irq.sv
// Vectored interrupt controller: synchronizes sources, latches pending events,
// and issues one request at a time to the interrupt control unit.
module vic_irq
  import vic_pkg::*;
#(
  parameter int NSRC      = 32,
  parameter int VEC_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  i_src,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_addr,
  input  logic [31:0]      i_cfg_wdata,
  output logic [31:0]      o_cfg_rdata,
  input  logic             i_reti,
  output logic             o_IRQ,
  output logic [VEC_W-1:0] o_ISR_addr,
  output logic             o_busy
);

  if (NSRC < 1 || NSRC > 32 || VEC_SHIFT < 0) begin : g_param_chk
    $error("vic_irq: NSRC must be within 1..32 and VEC_SHIFT non-negative");
  end

  logic [NSRC-1:0]  r_sync_p0, r_sync_p1, r_lvl_p2, r_hist_p3;
  logic [NSRC-1:0]  r_en, r_edge, r_pend;
  logic             r_win_vld_p4;
  logic [VEC_W-1:0] r_win_idx_p4;
  logic [VEC_W-1:0] r_isr_addr;
  vic_state_e       r_state, w_state_nxt;

  logic [NSRC-1:0]  w_evt, w_clr_wr, w_clr_sel, w_win_req;
  logic             w_win_vld, w_sel;
  logic [VEC_W-1:0] w_win_idx;

  // Stage p0/p1: two-flop synchronizer, p2/p3: level and history for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_lvl_p2  <= '0;
      r_hist_p3 <= '0;
    end else begin
      r_sync_p0 <= i_src;
      r_sync_p1 <= r_sync_p0;
      r_lvl_p2  <= r_sync_p1;
      r_hist_p3 <= r_lvl_p2;
    end
  end

  assign w_evt = (r_edge & r_lvl_p2 & ~r_hist_p3) | (~r_edge & r_lvl_p2);

  assign w_clr_wr = (i_cfg_we && i_cfg_addr == REG_PENDING) ?
                    i_cfg_wdata[NSRC-1:0] : '0;

  always_comb begin
    w_clr_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_clr_sel[i] = w_sel && (r_win_idx_p4 == VEC_W'(i));
    end
  end

  // New events override any clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_wr & ~w_clr_sel) | w_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= '0;
      r_edge <= '0;
    end else if (i_cfg_we) begin
      if (i_cfg_addr == REG_ENABLE) r_en   <= i_cfg_wdata[NSRC-1:0];
      if (i_cfg_addr == REG_EDGE)   r_edge <= i_cfg_wdata[NSRC-1:0];
    end
  end

  assign w_win_req = r_pend & r_en;

  vic_prio_enc #(.NSRC(NSRC)) u_prio (
    .i_req (w_win_req),
    .o_vld (w_win_vld),
    .o_idx (w_win_idx)
  );

  // Stage p4: registered winner; revalidated against live state before use
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_vld_p4 <= 1'b0;
      r_win_idx_p4 <= '0;
    end else begin
      r_win_vld_p4 <= w_win_vld;
      r_win_idx_p4 <= w_win_idx;
    end
  end

  assign w_sel = (r_state == ST_IDLE) && r_win_vld_p4 &&
                 r_pend[r_win_idx_p4] && r_en[r_win_idx_p4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_isr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sel) r_isr_addr <= r_win_idx_p4;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_sel) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_SERVICE;
      ST_SERVICE: if (i_reti) w_state_nxt = ST_RETIRE;
      ST_RETIRE:  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_IRQ      = (r_state == ST_ISSUE);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_ISR_addr = r_isr_addr;

  always_comb begin
    o_cfg_rdata = '0;
    case (i_cfg_addr)
      REG_ENABLE:  o_cfg_rdata = 32'(r_en);
      REG_EDGE:    o_cfg_rdata = 32'(r_edge);
      REG_PENDING: o_cfg_rdata = 32'(r_pend);
      REG_STATUS:  o_cfg_rdata = status_word(o_busy, r_isr_addr);
      default:     o_cfg_rdata = '0;
    endcase
  end

endmodule

// File: doc/vic_irq.md
VIC_IRQ -- requirements
Module: vic_irq

Interface
REQ-001 SHALL have parameter NSRC, default 32, meaning the number of interrupt sources (1..32).
REQ-002 SHALL have parameter VEC_SHIFT, default 4, meaning the ISR slot stride exponent, for documentation only (the vector is a 5-bit index).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- i_src  in  NSRC  raw peripheral interrupt lines, asynchronous to clk.
- i_cfg_we  in  1  configuration write strobe.
- i_cfg_addr  in  2  register select: 0 ENABLE, 1 EDGE, 2 PENDING, 3 STATUS.
- i_cfg_wdata  in  32  write data.
- o_cfg_rdata  out  32  combinational read of the register at i_cfg_addr.
- i_reti  in  1  one-cycle pulse when the ISR executes its return.
- o_IRQ  out  1  one-cycle interrupt request pulse to the interrupt control unit.
- o_ISR_addr  out  5  index of the source being serviced.
- o_busy  out  1  high while an interrupt is issued or in service.

Function
REQ-004 SHALL pass each i_src bit through a 2-flop synchronizer before any use.
REQ-005 SHALL treat EDGE[n]=1 sources as rising-edge events on the synchronized line; an event sets pending[n] for one cycle.
REQ-006 SHALL treat EDGE[n]=0 sources as level events; pending[n] is set every cycle the synchronized line is high.
REQ-007 SHALL set pending[n] on an event regardless of ENABLE[n]; ENABLE gates only selection.
REQ-008 SHALL select, among pending & ENABLE, the lowest index as highest priority.
REQ-009 SHALL implement FSM states IDLE, ISSUE, SERVICE, RETIRE.
REQ-010 IDLE: if any pending&ENABLE, latch the winner into o_ISR_addr, clear its pending bit, and go to ISSUE next cycle; otherwise stay in IDLE.
REQ-011 ISSUE: o_IRQ=1 for exactly this cycle; always go to SERVICE.
REQ-012 SERVICE: wait for i_reti; on i_reti go to RETIRE.
REQ-013 RETIRE: o_IRQ=0; always go to IDLE, guaranteeing at least 2 low cycles of o_IRQ between requests.
REQ-014 o_busy SHALL be 1 in ISSUE, SERVICE and RETIRE.
REQ-015 o_ISR_addr SHALL hold its value from ISSUE until the next IDLE selection; no preemption or nesting.
REQ-016 Latency: for an enabled edge source, i_src rising sampled at clock edge k gives pending set after edge k+3 and o_IRQ=1 in the cycle after edge k+5, provided the FSM is IDLE.
REQ-017 i_reti SHALL be ignored in IDLE, ISSUE and RETIRE.
REQ-018 An event on the source in service SHALL set its pending bit; that source is re-issued after RETIRE if still highest priority.
REQ-019 Writing PENDING SHALL be write-1-to-clear; an event in the same cycle as a clear on the same bit leaves the bit set (set wins).
REQ-020 ENABLE and EDGE SHALL be plain read/write registers; bits at or above NSRC read 0 and ignore writes.
REQ-021 STATUS SHALL read {26'b0, o_busy, o_ISR_addr}; writes to it are ignored.
REQ-022 Clearing ENABLE[n] while pending[n]=1 SHALL retain pending[n] without issuing it; re-enabling makes it eligible.
REQ-023 A configuration write in the same cycle as IDLE selection SHALL take effect from the following cycle.

Reset
REQ-024 On rst=1 at a clock edge: FSM=IDLE, o_IRQ=0, o_ISR_addr=0, o_busy=0, ENABLE=0, EDGE=0, pending=0, synchronizer and edge-history flops=0.
REQ-025 Reset asserted in any state, including SERVICE, SHALL abandon the in-service interrupt with no o_IRQ pulse.

Structure
REQ-026 A shared package vic_pkg SHALL hold register offsets, the FSM state enum, and the 5-bit vector width constant.
REQ-027 The lowest-index-first selector SHALL be a sub-module vic_prio_enc (NSRC-bit input; outputs valid and a 5-bit index).

Verification
REQ-028 Directed bench scenarios:
- ENABLE=0x1, EDGE=0x1, pulse i_src[0] -> one o_IRQ pulse, o_ISR_addr=0, cycle timing per REQ-016.
- Sources 5 and 3 raised together, both enabled -> 3 issued first; after i_reti, 5 issued no earlier than 2 cycles later.
- Level source 7 held high through i_reti -> re-issued with o_ISR_addr=7 after RETIRE.
- ENABLE=0, pulse src 2 -> PENDING reads 0x4 with no o_IRQ; then ENABLE=0x4 -> o_IRQ with addr 2; W1C racing a new event leaves the bit set.
- rst asserted in SERVICE -> o_busy=0, STATUS=0, no o_IRQ; i_reti pulse in IDLE -> no effect.
